imem_loader: RTL

- Writer side of the instruction memory: receives a program image as a byte stream and writes it word by word into instruction memory.
- Holds the processor in hold (cpu_hold=1) until the image is fully loaded, then releases it so fetch starts at BASE_ADDR.
- Sits between an external byte source (debug/boot link) and the instruction-memory write port.

---
 rtl/imem_loader_pkg.sv | 39 +++
 rtl/imem_loader_byte_pack.sv | 39 +++
 rtl/imem_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled with the IMEM_LOADER_CKSUM_EN macro.
package imem_loader_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int CNT_W  = 16;
   localparam int LANE_W = 2;

   // Byte distance between consecutive instructions (also the PC increment).
   localparam logic [WORD_W-1:0] INSTR_STEP = 32'd4;

   typedef enum logic [2:0] {
      LEN0  = 3'd0,
      LEN1  = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CKSUM = 3'd4,
      DONE  = 3'd5,
      ERROR = 3'd6
   } load_state_t;

   // Byte address of instruction slot idx relative to base.
   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
      return base + ({{(WORD_W-CNT_W){1'b0}}, idx} * INSTR_STEP);
   endfunction

   // States in which the loader consumes stream bytes.
   function automatic logic is_ready_state(input load_state_t st);
      logic r;
      case (st)
         LEN0, LEN1, DATA, CKSUM: r = 1'b1;
         default:                 r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imem_loader_byte_pack.sv
// Little-endian byte-to-word packer: four accepted bytes form one 32-bit word,
// first byte in bits [7:0]. word_valid flags the byte that completes a word,
// and word carries the completed value in that same cycle.
module imem_loader_byte_pack
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [LANE_W-1:0] lane_r;
   logic [WORD_W-1:0] shreg_r;

   assign word       = {byte_in, shreg_r[WORD_W-1:BYTE_W]};
   assign word_valid = byte_en && (lane_r == 2'd3);

   // Lane counter and shift register; clear drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_r  <= 2'd0;
         shreg_r <= 32'd0;
      end else if (clear) begin
         lane_r  <= 2'd0;
         shreg_r <= 32'd0;
      end else if (byte_en) begin
         lane_r  <= lane_r + 2'd1;
         shreg_r <= word;
      end else begin
         lane_r  <= lane_r;
         shreg_r <= shreg_r;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed little-endian byte
// stream, writes each word to instruction memory and releases the CPU once
// the image is complete. Define IMEM_LOADER_CKSUM_EN to require a trailing
// XOR checksum byte before the image is accepted.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                DEPTH_WORDS = 64,
   parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [WORD_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [CNT_W-1:0]  words_loaded
);

   localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH_WORDS);

`ifdef IMEM_LOADER_CKSUM_EN
   localparam load_state_t END_STATE = CKSUM;
`else
   localparam load_state_t END_STATE = DONE;
`endif

   load_state_t       state_r;
   load_state_t       state_next;
   logic [CNT_W-1:0]  len_r;
   logic [CNT_W-1:0]  len_next;
   logic [CNT_W-1:0]  words_r;
   logic              ready_r;
   logic              we_r;
   logic [WORD_W-1:0] addr_r;
   logic [WORD_W-1:0] wdata_r;
   logic              hold_r;
   logic              done_r;
   logic              err_r;
   logic              xfer;
   logic              pack_en;
   logic              word_valid;
   logic [WORD_W-1:0] packed_word;
   logic [CNT_W-1:0]  hdr_len;

   // A reload cycle never consumes a byte.
   assign in_ready     = ready_r & ~reload;
   assign xfer         = in_valid & in_ready;
   assign pack_en      = xfer && (state_r == DATA);
   assign hdr_len      = {in_data, len_r[BYTE_W-1:0]};

   assign imem_we      = we_r;
   assign imem_addr    = addr_r;
   assign imem_wdata   = wdata_r;
   assign cpu_hold     = hold_r;
   assign load_done    = done_r;
   assign load_err     = err_r;
   assign words_loaded = words_r;

   imem_loader_byte_pack u_pack (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (reload),
      .byte_en    (pack_en),
      .byte_in    (in_data),
      .word_valid (word_valid),
      .word       (packed_word)
   );

`ifdef IMEM_LOADER_CKSUM_EN
   logic [BYTE_W-1:0] xor_r;

   // Running XOR of every accepted stream byte since reset or reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_r <= 8'd0;
      end else if (reload) begin
         xor_r <= 8'd0;
      end else if (xfer) begin
         xor_r <= xor_r ^ in_data;
      end else begin
         xor_r <= xor_r;
      end
   end
`endif

   // Next-state and header capture; reload overrides everything.
   always_comb begin
      state_next = state_r;
      len_next   = len_r;
      if (reload) begin
         state_next = LEN0;
         len_next   = 16'd0;
      end else begin
         case (state_r)
            LEN0: begin
               if (xfer) begin
                  len_next   = {len_r[CNT_W-1:BYTE_W], in_data};
                  state_next = LEN1;
               end else begin
                  state_next = LEN0;
               end
            end
            LEN1: begin
               if (xfer) begin
                  len_next = hdr_len;
                  if (hdr_len > DEPTH_N) begin
                     state_next = ERROR;
                  end else if (hdr_len == 16'd0) begin
                     state_next = END_STATE;
                  end else begin
                     state_next = DATA;
                  end
               end else begin
                  state_next = LEN1;
               end
            end
            DATA: begin
               if (word_valid) begin
                  state_next = WRITE;
               end else begin
                  state_next = DATA;
               end
            end
            WRITE: begin
               if ((words_r + 16'd1) == len_r) begin
                  state_next = END_STATE;
               end else begin
                  state_next = DATA;
               end
            end
            CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
               if (xfer) begin
                  state_next = (in_data == xor_r) ? DONE : ERROR;
               end else begin
                  state_next = CKSUM;
               end
`else
               state_next = ERROR;
`endif
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
         endcase
      end
   end

   // State, header length and word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= LEN0;
         len_r   <= 16'd0;
         words_r <= 16'd0;
      end else begin
         state_r <= state_next;
         len_r   <= len_next;
         if (reload) begin
            words_r <= 16'd0;
         end else if (state_r == WRITE) begin
            words_r <= words_r + 16'd1;
         end else begin
            words_r <= words_r;
         end
      end
   end

   // Registered outputs decoded from the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= BASE_ADDR;
         wdata_r <= 32'd0;
         hold_r  <= 1'b1;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         ready_r <= is_ready_state(state_next);
         we_r    <= (state_next == WRITE);
         hold_r  <= (state_next != DONE);
         done_r  <= (state_next == DONE);
         err_r   <= (state_next == ERROR);
         if (state_next == WRITE) begin
            addr_r  <= word_addr(BASE_ADDR, words_r);
            wdata_r <= packed_word;
         end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
         end
      end
   end

endmodule
